operand_entry_ctrl: RTL and testbench
=====================================

OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand width in bits (two's complement).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port key_valid  input  1  keypad code present on key_code.
REQ-005 SHALL have port key_code  input  4  0-9 digit, 10 negate, 11 clear, 12 enter, 13-15 unused.
REQ-006 SHALL have port key_ready  output  1  block can accept a key this cycle.
REQ-007 SHALL have port op_ready  input  1  downstream accepts operand.
REQ-008 SHALL have port op_valid  output  1  operand is complete and held.
REQ-009 SHALL have port operand  output  N  signed result, two's complement.
REQ-010 SHALL have port mag  output  N-1  current magnitude, for display.
REQ-011 SHALL have port sign  output  1  current sign, 1 = negative, for display.
REQ-012 SHALL have port err  output  1  sticky flag: a digit was rejected for overflow.

Function
REQ-013 SHALL implement FSM states IDLE (no entry), ENTRY (entry in progress), ACCUM (one-cycle digit accumulate), HOLD (operand offered).
REQ-014 SHALL drive key_ready=1 in IDLE and ENTRY and 0 in ACCUM and HOLD; a key is accepted only when key_valid & key_ready.
REQ-015 SHALL, on an accepted digit d, latch d and go to ACCUM.
REQ-016 SHALL, in ACCUM, compute t = mag*10 + d at width N+4; if t <= 2^(N-1)-1, set mag=t, else leave mag unchanged and set err=1; then go to ENTRY unconditionally after exactly one cycle.
REQ-017 SHALL, on an accepted negate in IDLE or ENTRY, toggle sign and go to or stay in ENTRY; mag is unchanged.
REQ-018 SHALL, on an accepted clear in IDLE or ENTRY, set mag=0, sign=0, err=0 and go to IDLE.
REQ-019 SHALL, on an accepted enter in ENTRY, register operand = sign ? (~{0,mag}+1) mod 2^N : {0,mag}, set op_valid=1 and go to HOLD.
REQ-020 SHALL treat enter in IDLE and codes 13-15 in any accepting state as consumed no-ops with no state change.
REQ-021 SHALL produce operand=0 for sign=1, mag=0 (negative zero collapses to zero).
REQ-022 SHALL hold operand, op_valid, mag and sign stable in HOLD until op_valid & op_ready.
REQ-023 SHALL, on op_valid & op_ready, clear op_valid, mag, sign and err, and go to IDLE on the next cycle; operand retains its last value.
REQ-024 SHALL set err only in ACCUM, and SHALL clear it only via clear, handshake completion or reset.
REQ-025 SHALL ignore op_ready outside HOLD and ignore key_code whenever key_ready=0.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, force state=IDLE, mag=0, sign=0, err=0, operand=0 and op_valid=0; key_ready reads 1 in the following cycle.
REQ-027 SHALL give reset priority over every key and handshake event, including in ACCUM and HOLD.

Verification
REQ-028 Bench SHALL cover: N=8, keys 1,2,7,enter -> op_valid=1, operand=0x7F, err=0; op_ready pulse -> IDLE, mag=0.
REQ-029 Bench SHALL cover: keys 1,2,8 -> third digit rejected, err=1, mag=12; enter -> operand=0x0C, err still 1 until handshake.
REQ-030 Bench SHALL cover: keys 5,negate,enter -> operand=0xFB; keys 5,negate,negate,enter -> operand=0x05; negate,enter from IDLE -> operand=0x00.
REQ-031 Bench SHALL cover: key_valid held high with a new digit through ACCUM -> key_ready=0 for that cycle and the digit is consumed once, next cycle.
REQ-032 Bench SHALL cover: op_ready low for 10 cycles in HOLD -> operand and op_valid constant, keys ignored.
REQ-033 Bench SHALL cover: reset asserted in ACCUM and in HOLD, and clear key in ENTRY -> all outputs at REQ-026 values, err=0.

Source files
------------

// File: rtl/operand_entry_ctrl.sv
// Keypad operand entry: accumulates decimal digits into a sign/magnitude value,
// then offers it as an N-bit two's-complement operand with a valid/ready handshake.
module operand_entry_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic         key_ready,
    input  logic         op_ready,
    output logic         op_valid,
    output logic [N-1:0] operand,
    output logic [N-2:0] mag,
    output logic         sign,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_ACCUM = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0]   K_NEG   = 4'd10;
    localparam logic [3:0]   K_CLEAR = 4'd11;
    localparam logic [3:0]   K_ENTER = 4'd12;
    localparam logic [N+3:0] MAX_POS = {5'b0, {(N-1){1'b1}}};
    localparam logic [N+3:0] TEN     = (N+4)'(10);

    state_t       r_state, w_state_next;
    logic [3:0]   r_digit, w_digit_next;
    logic [N-2:0] r_mag, w_mag_next;
    logic         r_sign, w_sign_next;
    logic         r_err, w_err_next;
    logic [N-1:0] r_operand, w_operand_next;
    logic         r_op_valid, w_op_valid_next;

    logic         w_key_fire;
    logic [N+3:0] w_accum;
    logic [N-1:0] w_signed_val;

    assign key_ready  = (r_state == S_IDLE) || (r_state == S_ENTRY);
    assign w_key_fire = key_valid & key_ready;

    // Width N+4 leaves headroom so mag*10+9 never wraps before the range test.
    assign w_accum = ({5'b0, r_mag} * TEN) + {{N{1'b0}}, r_digit};

    // Negating a zero magnitude yields zero, so "-0" needs no special case.
    assign w_signed_val = r_sign ? ((~{1'b0, r_mag}) + N'(1)) : {1'b0, r_mag};

    always_comb begin
        w_state_next    = r_state;
        w_digit_next    = r_digit;
        w_mag_next      = r_mag;
        w_sign_next     = r_sign;
        w_err_next      = r_err;
        w_operand_next  = r_operand;
        w_op_valid_next = r_op_valid;

        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (w_key_fire) begin
                    if (key_code <= 4'd9) begin
                        w_digit_next = key_code;
                        w_state_next = S_ACCUM;
                    end else if (key_code == K_NEG) begin
                        w_sign_next  = ~r_sign;
                        w_state_next = S_ENTRY;
                    end else if (key_code == K_CLEAR) begin
                        w_mag_next   = '0;
                        w_sign_next  = 1'b0;
                        w_err_next   = 1'b0;
                        w_state_next = S_IDLE;
                    end else if (key_code == K_ENTER && r_state == S_ENTRY) begin
                        w_operand_next  = w_signed_val;
                        w_op_valid_next = 1'b1;
                        w_state_next    = S_HOLD;
                    end
                end
            end
            S_ACCUM: begin
                if (w_accum <= MAX_POS) begin
                    w_mag_next = w_accum[N-2:0];
                end else begin
                    w_err_next = 1'b1;
                end
                w_state_next = S_ENTRY;
            end
            S_HOLD: begin
                if (r_op_valid && op_ready) begin
                    w_op_valid_next = 1'b0;
                    w_mag_next      = '0;
                    w_sign_next     = 1'b0;
                    w_err_next      = 1'b0;
                    w_state_next    = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_digit    <= '0;
            r_mag      <= '0;
            r_sign     <= 1'b0;
            r_err      <= 1'b0;
            r_operand  <= '0;
            r_op_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_digit    <= w_digit_next;
            r_mag      <= w_mag_next;
            r_sign     <= w_sign_next;
            r_err      <= w_err_next;
            r_operand  <= w_operand_next;
            r_op_valid <= w_op_valid_next;
        end
    end

    assign op_valid = r_op_valid;
    assign operand  = r_operand;
    assign mag      = r_mag;
    assign sign     = r_sign;
    assign err      = r_err;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl (N=8): digit entry, overflow, sign,
// handshake hold, back-to-back keys through ACCUM, and reset/clear recovery.
module tb_operand_entry_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         key_ready;
    logic         op_ready;
    logic         op_valid;
    logic [N-1:0] operand;
    logic [N-2:0] mag;
    logic         sign;
    logic         err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operand_entry_ctrl #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .op_ready  (op_ready),
        .op_valid  (op_valid),
        .operand   (operand),
        .mag       (mag),
        .sign      (sign),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One key pulse followed by an idle cycle so any ACCUM step completes.
    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        tick();
    endtask

    task automatic handshake();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_key_ready"}, 32'(key_ready), 32'd1);
        chk({tag, "_op_valid"},  32'(op_valid),  32'd0);
        chk({tag, "_operand"},   32'(operand),   32'h00);
        chk({tag, "_mag"},       32'(mag),       32'd0);
        chk({tag, "_sign"},      32'(sign),      32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        op_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_vals("rst");

        // 1,2,7 -> +127, the largest positive value
        press(4'd1); press(4'd2); press(4'd7);
        chk("t1_mag", 32'(mag), 32'd127);
        press(4'd12);
        chk("t1_op_valid", 32'(op_valid), 32'd1);
        chk("t1_operand", 32'(operand), 32'h7F);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_key_ready_hold", 32'(key_ready), 32'd0);
        handshake();
        chk("t1_op_valid_after", 32'(op_valid), 32'd0);
        chk("t1_mag_after", 32'(mag), 32'd0);
        chk("t1_operand_kept", 32'(operand), 32'h7F);
        chk("t1_key_ready_idle", 32'(key_ready), 32'd1);

        // 1,2,8 -> 128 overflows; mag stays 12, err sticks until handshake
        press(4'd1); press(4'd2); press(4'd8);
        chk("t2_mag", 32'(mag), 32'd12);
        chk("t2_err", 32'(err), 32'd1);
        press(4'd12);
        chk("t2_operand", 32'(operand), 32'h0C);
        chk("t2_err_hold", 32'(err), 32'd1);
        handshake();
        chk("t2_err_cleared", 32'(err), 32'd0);

        // sign handling
        press(4'd5); press(4'd10); press(4'd12);
        chk("t3a_operand", 32'(operand), 32'hFB);
        handshake();
        press(4'd5); press(4'd10); press(4'd10); press(4'd12);
        chk("t3b_operand", 32'(operand), 32'h05);
        handshake();
        press(4'd10); press(4'd12);
        chk("t3c_op_valid", 32'(op_valid), 32'd1);
        chk("t3c_operand", 32'(operand), 32'h00);
        chk("t3c_sign", 32'(sign), 32'd1);
        handshake();
        chk("t3c_sign_after", 32'(sign), 32'd0);

        // key_valid held through ACCUM: second digit taken once, one cycle later
        key_valid = 1'b1;
        key_code  = 4'd3;
        tick();
        key_code = 4'd4;
        chk("t4_key_ready_accum", 32'(key_ready), 32'd0);
        tick();
        chk("t4_key_ready_entry", 32'(key_ready), 32'd1);
        chk("t4_mag_first", 32'(mag), 32'd3);
        tick();
        key_valid = 1'b0;
        tick();
        chk("t4_mag_second", 32'(mag), 32'd34);
        tick();
        chk("t4_mag_once", 32'(mag), 32'd34);
        // unused code 13 is a no-op in ENTRY; enter in ENTRY then commits
        press(4'd13);
        chk("t4_mag_noop", 32'(mag), 32'd34);
        chk("t4_key_ready_noop", 32'(key_ready), 32'd1);
        press(4'd12);
        chk("t4_operand", 32'(operand), 32'h22);
        handshake();

        // HOLD with op_ready low for 10 cycles while keys are presented
        press(4'd9); press(4'd12);
        key_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            key_code = (i % 2 == 0) ? 4'd7 : 4'd11;
            tick();
            chk($sformatf("t5_operand_%0d", i), 32'(operand), 32'h09);
            chk($sformatf("t5_op_valid_%0d", i), 32'(op_valid), 32'd1);
            chk($sformatf("t5_mag_%0d", i), 32'(mag), 32'd9);
        end
        key_valid = 1'b0;
        handshake();
        chk("t5_op_valid_after", 32'(op_valid), 32'd0);

        // reset while in ACCUM, with err already set
        press(4'd1); press(4'd2); press(4'd8);
        chk("t6a_err_pre", 32'(err), 32'd1);
        key_valid = 1'b1;
        key_code  = 4'd6;
        tick();
        key_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("t6a");

        // reset while in HOLD
        press(4'd1); press(4'd2); press(4'd8); press(4'd12);
        chk("t6b_op_valid_pre", 32'(op_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("t6b");

        // clear key in ENTRY, then enter in IDLE is a no-op
        press(4'd1); press(4'd2); press(4'd8); press(4'd10);
        chk("t6c_sign_pre", 32'(sign), 32'd1);
        press(4'd11);
        chk_reset_vals("t6c");
        press(4'd12);
        chk("t6c_enter_idle", 32'(op_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
